// File: rtl/bridge_pkg.sv
// Frame constants and hex helper shared by the UART host bridge transmit and receive sides.
package bridge_pkg;

  localparam logic [7:0] RESP_CHAR = 8'h4D;
  localparam logic [7:0] CR        = 8'h0D;
  localparam logic [7:0] LF        = 8'h0A;
  localparam int         FRAME_LEN = 7;
  localparam logic [2:0] LAST_IDX  = 3'(FRAME_LEN - 1);

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_t;

  function automatic logic [7:0] to_ascii_hex(input logic [3:0] nib);
    logic [7:0] wide;
    wide = {4'h0, nib};
    return (nib < 4'd10) ? (8'h30 + wide) : (8'h37 + wide);
  endfunction

endpackage

// File: rtl/bridge_tx.sv
// Serialises bus read data as "M" + four hex digits + CR LF onto a byte valid/ready stream,
// with a one-entry holding register for a read that lands mid-frame.
module bridge_tx
  import bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] data_i,
  input  logic        rw_i,
  input  logic        valid_i,
  output logic [7:0]  data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        busy_o,
  output logic        overrun_o
);

  tx_state_t   state;
  logic [2:0]  idx;
  logic [15:0] shift_q;
  logic [15:0] hold_q;
  logic        hold_full;
  logic        overrun;

  logic rd_req;
  logic fire;
  logic last_fire;

  assign rd_req    = valid_i && !rw_i;
  assign fire      = valid_o && ready_i;
  assign last_fire = fire && (idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= TX_IDLE;
      idx       <= 3'd0;
      shift_q   <= 16'h0000;
      hold_q    <= 16'h0000;
      hold_full <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      case (state)
        TX_IDLE: begin
          if (rd_req) begin
            shift_q <= data_i;
            idx     <= 3'd0;
            state   <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (last_fire) begin
            idx <= 3'd0;
            if (hold_full) begin
              // Chain straight into the held frame; a read this cycle still sees a full holder.
              shift_q   <= hold_q;
              hold_full <= 1'b0;
              if (rd_req) overrun <= 1'b1;
            end else if (rd_req) begin
              shift_q <= data_i;
            end else begin
              state <= TX_IDLE;
            end
          end else begin
            if (fire) idx <= idx + 3'd1;
            if (rd_req) begin
              if (hold_full) begin
                overrun <= 1'b1;
              end else begin
                hold_q    <= data_i;
                hold_full <= 1'b1;
              end
            end
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

  assign valid_o   = (state == TX_SEND);
  assign busy_o    = (state == TX_SEND) || hold_full;
  assign overrun_o = overrun;

  always_comb begin
    data_o = 8'h00;
    if (state == TX_SEND) begin
      case (idx)
        3'd0:    data_o = RESP_CHAR;
        3'd1:    data_o = to_ascii_hex(shift_q[15:12]);
        3'd2:    data_o = to_ascii_hex(shift_q[11:8]);
        3'd3:    data_o = to_ascii_hex(shift_q[7:4]);
        3'd4:    data_o = to_ascii_hex(shift_q[3:0]);
        3'd5:    data_o = CR;
        3'd6:    data_o = LF;
        default: data_o = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_bridge_tx.sv
// Scoreboard bench for bridge_tx: stimulus pushes hand-computed frame bytes, a monitor pops on each handshake.
module tb_bridge_tx;

  logic        clk;
  logic        rst_n;
  logic [15:0] data_i;
  logic        rw_i;
  logic        valid_i;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        ready_i;
  logic        busy_o;
  logic        overrun_o;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];

  bridge_tx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_i    (data_i),
    .rw_i      (rw_i),
    .valid_i   (valid_i),
    .data_o    (data_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .busy_o    (busy_o),
    .overrun_o (overrun_o)
  );

  always #5 clk = ~clk;

  // Monitor: every accepted byte must match the next expected one; stalled bytes must not change.
  logic       stall;
  logic [7:0] stall_data;
  logic [7:0] exp_byte;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall = 1'b0;
    end else begin
      if (stall && valid_o) begin
        checks++;
        if (data_o !== stall_data) begin
          errors++;
          $display("FAIL stall_stable: got %02h, required %02h", data_o, stall_data);
        end
      end
      if (valid_o && ready_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: got %02h, required no byte", data_o);
        end else begin
          exp_byte = exp_q.pop_front();
          if (data_o !== exp_byte) begin
            errors++;
            $display("FAIL frame_byte: got %02h, required %02h", data_o, exp_byte);
          end
        end
      end
      stall      = valid_o && !ready_i;
      stall_data = data_o;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic push7(input logic [55:0] v);
    for (int i = 6; i >= 0; i--) exp_q.push_back(v[i*8 +: 8]);
  endtask

  // Called just after a rising edge; leaves the strobe low just after the next one.
  task automatic strobe(input logic rw, input logic [15:0] d);
    valid_i = 1'b1;
    rw_i    = rw;
    data_i  = d;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    rw_i    = 1'b0;
  endtask

  // Called at a falling edge; counts consecutive cycles with valid_o high.
  task automatic count_valid(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (!valid_o) break;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int max_cycles);
    logic done;
    done = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (!valid_o && !busy_o) begin
        done = 1'b1;
        break;
      end
    end
    chk("idle_timeout", {31'd0, done}, 32'd1);
  endtask

  int n;

  initial begin
    clk     = 1'b0;
    rst_n   = 1'b0;
    data_i  = 16'h0000;
    rw_i    = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;

    #12;
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_data", {24'd0, data_o}, 32'h00);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_overrun", {31'd0, overrun_o}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single read, ready held high: seven bytes back to back.
    push7(56'h4D_31_32_33_34_0D_0A);
    strobe(1'b0, 16'h1234);
    @(negedge clk);
    chk("latency_valid", {31'd0, valid_o}, 32'd1);
    chk("latency_data", {24'd0, data_o}, 32'h4D);
    count_valid(n);
    chk("single_len", n, 32'd7);
    chk("single_busy_after", {31'd0, busy_o}, 32'd0);
    @(posedge clk); #1;

    // Backpressure: ready toggles every cycle.
    push7(56'h4D_41_42_43_46_0D_0A);
    strobe(1'b0, 16'hABCF);
    for (int i = 0; i < 40; i++) begin
      ready_i = ~ready_i;
      @(posedge clk); #1;
      if (!busy_o) break;
    end
    chk("toggle_done_busy", {31'd0, busy_o}, 32'd0);
    chk("toggle_done_valid", {31'd0, valid_o}, 32'd0);
    ready_i = 1'b1;
    @(posedge clk); #1;

    // Write completion is ignored.
    strobe(1'b1, 16'hFFFF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("write_valid", {31'd0, valid_o}, 32'd0);
      chk("write_busy", {31'd0, busy_o}, 32'd0);
    end
    @(posedge clk); #1;

    // Two reads two cycles apart chain into 14 consecutive bytes.
    push7(56'h4D_30_30_30_31_0D_0A);
    push7(56'h4D_46_46_46_46_0D_0A);
    strobe(1'b0, 16'h0001);
    fork
      begin
        @(posedge clk); #1;
        strobe(1'b0, 16'hFFFF);
      end
      begin
        @(negedge clk);
        count_valid(n);
      end
    join
    chk("chain_len", n, 32'd14);
    chk("chain_overrun", {31'd0, overrun_o}, 32'd0);
    @(posedge clk); #1;

    // Three reads while stalled: third is dropped and flags overrun.
    ready_i = 1'b0;
    push7(56'h4D_35_41_33_43_0D_0A);
    push7(56'h4D_30_46_30_46_0D_0A);
    strobe(1'b0, 16'h5A3C);
    strobe(1'b0, 16'h0F0F);
    @(negedge clk);
    chk("held_overrun", {31'd0, overrun_o}, 32'd0);
    chk("held_busy", {31'd0, busy_o}, 32'd1);
    chk("held_first_byte", {24'd0, data_o}, 32'h4D);
    @(posedge clk); #1;
    strobe(1'b0, 16'hDEAD);
    @(negedge clk);
    chk("drop_overrun", {31'd0, overrun_o}, 32'd1);
    @(posedge clk); #1;
    ready_i = 1'b1;
    wait_idle(100);
    chk("overrun_sticky", {31'd0, overrun_o}, 32'd1);
    chk("drop_queue_empty", exp_q.size(), 32'd0);
    @(posedge clk); #1;

    // Reset mid-frame after byte 2 is accepted.
    exp_q.push_back(8'h4D);
    exp_q.push_back(8'h37);
    exp_q.push_back(8'h38);
    strobe(1'b0, 16'h789A);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, valid_o}, 32'd0);
    chk("midrst_data", {24'd0, data_o}, 32'h00);
    chk("midrst_busy", {31'd0, busy_o}, 32'd0);
    chk("midrst_overrun", {31'd0, overrun_o}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_valid", {31'd0, valid_o}, 32'd0);
    @(posedge clk); #1;
    push7(56'h4D_30_30_30_30_0D_0A);
    strobe(1'b0, 16'h0000);
    @(negedge clk);
    count_valid(n);
    chk("postrst_len", n, 32'd7);
    @(posedge clk); #1;

    chk("final_queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
